// File: rtl/done_req_ack.sv
// rtl/done_req_ack.sv - queues done pulses and delivers them over a 4-phase req/ack handshake
// Flags events dropped at saturation (sticky) and requests left unanswered (pulse).
module done_req_ack #(
  parameter int PEND_W  = 3,
  parameter int TMO_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              done_i,
  input  logic              ack_i,
  input  logic              clr_i,
  output logic              req_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              busy_o,
  output logic              ovf_o,
  output logic              tmo_o
);

  localparam int TMR_W = $clog2(TMO_CYC);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TMO_CYC - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  state_t            r_state;
  logic              r_req;
  logic [PEND_W-1:0] r_pend;
  logic              r_ovf;
  logic              r_tmo;
  logic [TMR_W-1:0]  r_timer;

  state_t            w_state_nxt;
  logic              w_req_nxt;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              w_ovf_nxt;
  logic              w_tmo_nxt;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic              w_launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_pend  <= '0;
      r_ovf   <= 1'b0;
      r_tmo   <= 1'b0;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_pend  <= w_pend_nxt;
      r_ovf   <= w_ovf_nxt;
      r_tmo   <= w_tmo_nxt;
      r_timer <= w_timer_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_tmo_nxt   = 1'b0;
    w_timer_nxt = r_timer;
    w_launch    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend != '0) begin
          w_state_nxt = S_REQ;
          w_req_nxt   = 1'b1;
          w_launch    = 1'b1;
          w_timer_nxt = '0;
        end
      end
      S_REQ: begin
        // ack wins over a timeout landing in the same cycle
        if (ack_i) begin
          w_state_nxt = S_REL;
          w_req_nxt   = 1'b0;
        end else if (r_timer == TMR_LAST) begin
          w_state_nxt = S_REL;
          w_req_nxt   = 1'b0;
          w_tmo_nxt   = 1'b1;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_REL: begin
        if (!ack_i) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // Overflow set is evaluated after clear so a coincident drop keeps the flag
  always_comb begin
    w_pend_nxt = r_pend;
    w_ovf_nxt  = r_ovf;
    if (clr_i) w_ovf_nxt = 1'b0;
    if (done_i && !w_launch) begin
      if (r_pend == PEND_MAX) w_ovf_nxt = 1'b1;
      else                    w_pend_nxt = r_pend + 1'b1;
    end else if (!done_i && w_launch) begin
      w_pend_nxt = r_pend - 1'b1;
    end
  end

  assign req_o  = r_req;
  assign pend_o = r_pend;
  assign busy_o = (r_state != S_IDLE);
  assign ovf_o  = r_ovf;
  assign tmo_o  = r_tmo;

endmodule

// File: tb/tb_done_req_ack.sv
// tb/tb_done_req_ack.sv - directed-vector bench for done_req_ack
module tb_done_req_ack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done_i;
  logic       ack_drv;
  logic       auto_ack;
  logic       ack_i;
  logic       clr_i;
  logic       req_o;
  logic [2:0] pend_o;
  logic       busy_o;
  logic       ovf_o;
  logic       tmo_o;

  int n_vec   = 0;
  int n_err   = 0;
  int tmo_cnt = 0;

  // Consumer model: either driven directly or answering req_o in the same cycle
  assign ack_i = auto_ack ? req_o : ack_drv;

  always #5 clk = ~clk;

  done_req_ack #(.PEND_W(3), .TMO_CYC(15)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .done_i (done_i),
    .ack_i  (ack_i),
    .clr_i  (clr_i),
    .req_o  (req_o),
    .pend_o (pend_o),
    .busy_o (busy_o),
    .ovf_o  (ovf_o),
    .tmo_o  (tmo_o)
  );

  task automatic chk_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (tmo_o) tmo_cnt++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    done_i   = 1'b0;
    ack_drv  = 1'b0;
    auto_ack = 1'b0;
    clr_i    = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    tmo_cnt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n_hi;
    int rises;
    int hit;
    logic prev;
    logic [9:0] hist;

    // reset state
    do_reset();
    chk_eq("rst_req", req_o, 0);
    chk_eq("rst_pend", pend_o, 0);
    chk_eq("rst_busy", busy_o, 0);
    chk_eq("rst_ovf", ovf_o, 0);
    chk_eq("rst_tmo", tmo_o, 0);

    // 1: single event, normal handshake
    done_i = 1'b1;
    tick();                                   // c1
    done_i = 1'b0;
    chk_eq("t1_pend_c1", pend_o, 1);
    chk_eq("t1_req_c1", req_o, 0);
    tick();                                   // c2
    chk_eq("t1_req_c2", req_o, 1);
    chk_eq("t1_pend_c2", pend_o, 0);
    chk_eq("t1_busy_c2", busy_o, 1);
    tick();                                   // c3
    chk_eq("t1_req_c3", req_o, 1);
    tick();                                   // c4
    ack_drv = 1'b1;
    tick();                                   // c5
    chk_eq("t1_req_c5", req_o, 0);
    chk_eq("t1_busy_c5", busy_o, 1);
    tick();                                   // c6
    ack_drv = 1'b0;
    chk_eq("t1_busy_c6", busy_o, 1);
    tick();                                   // c7
    chk_eq("t1_busy_c7", busy_o, 0);
    chk_eq("t1_tmo_none", tmo_cnt, 0);
    chk_eq("t1_ovf", ovf_o, 0);

    // 2: saturation, overflow, clear, and set-beats-clear
    do_reset();
    rises = 0;
    prev  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      done_i = 1'b1;
      tick();
      if (req_o && !prev) rises++;
      prev = req_o;
      if (i == 0) chk_eq("t2_pend_c1", pend_o, 1);
      if (i == 1) begin
        chk_eq("t2_req_c2", req_o, 1);
        chk_eq("t2_pend_c2", pend_o, 1);
      end
    end
    done_i = 1'b0;                            // c10
    chk_eq("t2_pend_sat", pend_o, 7);
    chk_eq("t2_ovf_set", ovf_o, 1);
    chk_eq("t2_launches", rises, 1);
    clr_i = 1'b1;
    tick();                                   // c11
    clr_i = 1'b0;
    chk_eq("t2_ovf_clr", ovf_o, 0);
    chk_eq("t2_pend_keep", pend_o, 7);
    done_i = 1'b1;
    clr_i  = 1'b1;
    tick();                                   // c12
    done_i = 1'b0;
    clr_i  = 1'b0;
    chk_eq("t2_ovf_set_wins", ovf_o, 1);
    chk_eq("t2_pend_still7", pend_o, 7);

    // 3: timeout with one more event queued during the request
    do_reset();
    done_i = 1'b1;
    tick();                                   // c1
    done_i = 1'b0;
    n_hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      done_i = (k == 1);
      if (req_o) n_hi++;
      else if (n_hi > 0) break;
    end
    done_i = 1'b0;
    chk_eq("t3_req_high_cycles", n_hi, 15);
    chk_eq("t3_req_low", req_o, 0);
    chk_eq("t3_tmo_pulse", tmo_o, 1);
    chk_eq("t3_pend_kept", pend_o, 1);
    chk_eq("t3_busy_rel", busy_o, 1);
    tick();
    chk_eq("t3_tmo_one_cycle", tmo_o, 0);
    chk_eq("t3_busy_idle", busy_o, 0);
    tick();
    chk_eq("t3_relaunch", req_o, 1);
    chk_eq("t3_tmo_total", tmo_cnt, 1);

    // 4: ack on the last allowed request cycle beats the timeout
    do_reset();
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    n_hi = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (req_o) n_hi++;
      if (n_hi == 15) break;
    end
    chk_eq("t4_reach_15", n_hi, 15);
    ack_drv = 1'b1;
    tick();
    chk_eq("t4_req_low", req_o, 0);
    chk_eq("t4_no_tmo", tmo_o, 0);
    chk_eq("t4_busy_rel", busy_o, 1);
    ack_drv = 1'b0;
    tick();
    chk_eq("t4_busy_idle", busy_o, 0);
    chk_eq("t4_tmo_total", tmo_cnt, 0);

    // 5: inc+dec in the launch cycle, then back-to-back launches
    do_reset();
    auto_ack = 1'b1;
    done_i = 1'b1;
    tick();                                   // c1
    done_i = 1'b0;
    tick();                                   // c2
    done_i = 1'b1;
    tick();                                   // c3
    tick();                                   // c4
    chk_eq("t5_pend_idle", pend_o, 2);
    chk_eq("t5_busy_idle", busy_o, 0);
    tick();                                   // c5
    done_i = 1'b0;
    chk_eq("t5_pend_stays", pend_o, 2);
    hist = '0;
    hist[0] = req_o;
    for (int k = 1; k < 10; k++) begin
      tick();
      hist[k] = req_o;
      if (k == 6) chk_eq("t5_pend_c11", pend_o, 0);
    end
    chk_eq("t5_req_pattern", hist, 10'b0001001001);

    // 6: async reset mid-request with events pending and overflow set
    do_reset();
    for (int i = 0; i < 10; i++) begin
      done_i = 1'b1;
      tick();
    end
    done_i = 1'b0;
    chk_eq("t6_ovf_pre", ovf_o, 1);
    auto_ack = 1'b1;
    hit = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (req_o && pend_o == 3'd3) begin
        hit = 1;
        break;
      end
    end
    chk_eq("t6_reach_req_pend3", hit, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("t6_async_req", req_o, 0);
    chk_eq("t6_async_pend", pend_o, 0);
    chk_eq("t6_async_busy", busy_o, 0);
    chk_eq("t6_async_ovf", ovf_o, 0);
    chk_eq("t6_async_tmo", tmo_o, 0);
    #2 rst_n = 1'b1;
    rises = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (req_o) rises++;
    end
    chk_eq("t6_no_req_after_rst", rises, 0);
    chk_eq("t6_pend_after_rst", pend_o, 0);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    tick();
    chk_eq("t6_new_req", req_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
